line_buffer_3row: RTL

- Upstream feeder for the convolution stage.
- Accepts a raster pixel stream, one pixel per accepted beat, and stores it in four circular row slots of IMG_WIDTH pixels each.
- Once three complete rows are held, each shift request returns one vertical 3-pixel column (oldest row first) for the sliding window.
- The fourth slot lets the next row fill while the current three rows are being read.

---
 rtl/line_buffer_3row.sv | 124 ++++++++++++
 1 files changed

// File: rtl/line_buffer_3row.sv
// Four-slot circular row buffer that feeds 3-pixel vertical columns to the convolution window.
// Optional build macro LB_UNDERRUN_FLAG_EN adds a sticky underrun flag and a retired-row counter.
module line_buffer_3row #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_WIDTH = 28,
    parameter int COL_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           stride,
    input  logic [BIT_DEPTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 shift_buffer,
    output logic                 rows_avail,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
`ifdef LB_UNDERRUN_FLAG_EN
    output logic                 underrun,
    output logic [15:0]          row_count,
`endif
    output logic                 out_valid
);

    localparam int DEPTH = 4 * IMG_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [BIT_DEPTH-1:0] mem [DEPTH];

    logic [1:0]       wr_row, rd_row;
    logic [COL_W-1:0] wr_col, rd_col;
    logic [2:0]       full_rows, full_rows_next;

    logic       clear, accept, shift_ok, row_done, retire;
    logic [1:0] eff_stride;
    logic [AW-1:0] wr_addr, rd_addr1, rd_addr2, rd_addr3;

    // Slots are laid out back to back so one flat array holds all four rows.
    function automatic logic [AW-1:0] slot_addr(input logic [1:0] row, input logic [COL_W-1:0] col);
        return AW'(int'(row) * IMG_WIDTH + int'(col));
    endfunction

    assign clear      = rst || flush;
    assign s_ready    = (full_rows < 3'd4);
    assign rows_avail = (full_rows >= 3'd3);
    assign accept     = s_valid && s_ready;
    assign shift_ok   = shift_buffer && rows_avail;
    assign row_done   = accept && (wr_col == LAST_COL);
    assign retire     = shift_ok && (rd_col == LAST_COL);
    assign eff_stride = (stride == 2'd0) ? 2'd1 : stride;

    assign wr_addr  = slot_addr(wr_row, wr_col);
    assign rd_addr1 = slot_addr(rd_row, rd_col);
    assign rd_addr2 = slot_addr(rd_row + 2'd1, rd_col);
    assign rd_addr3 = slot_addr(rd_row + 2'd2, rd_col);

    // A row completing and a row retiring in the same cycle must net out.
    always_comb begin
        full_rows_next = full_rows;
        if (row_done)
            full_rows_next = full_rows_next + 3'd1;
        if (retire)
            full_rows_next = full_rows_next - {1'b0, eff_stride};
    end

    always_ff @(posedge clk) begin
        if (accept && !clear)
            mem[wr_addr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_row    <= 2'd0;
            wr_col    <= '0;
            rd_row    <= 2'd0;
            rd_col    <= '0;
            full_rows <= 3'd0;
            out_valid <= 1'b0;
            out_l1    <= '0;
            out_l2    <= '0;
            out_l3    <= '0;
        end else begin
            full_rows <= full_rows_next;
            out_valid <= shift_ok;
            if (accept) begin
                if (row_done) begin
                    wr_col <= '0;
                    wr_row <= wr_row + 2'd1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (shift_ok) begin
                out_l1 <= mem[rd_addr1];
                out_l2 <= mem[rd_addr2];
                out_l3 <= mem[rd_addr3];
                if (retire) begin
                    rd_col <= '0;
                    rd_row <= rd_row + eff_stride;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

`ifdef LB_UNDERRUN_FLAG_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            underrun  <= 1'b0;
            row_count <= 16'd0;
        end else begin
            if (shift_buffer && !rows_avail)
                underrun <= 1'b1;
            if (retire)
                row_count <= row_count + 16'd1;
        end
    end
`endif

endmodule
